equiv_checker: RTL and testbench

Hardware response checker for equivalence runs: sits on the output side of an exhaustive W-bit stimulus sweep and watches N parallel implementations of the same combinational function. Each sampled vector is compared across all N results, a majority-vote reference is formed, and disagreements are tallied. The block reports pass/fail, the first failing vector, and which implementations ever disagreed, once the sweep completes.

---
 rtl/equiv_checker.sv | 115 +++++++++++
 tb/tb_equiv_checker.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/equiv_checker.sv
// Response checker for exhaustive equivalence sweeps: majority-votes N parallel
// implementations per vector, tallies disagreements and reports a pass/fail verdict.

module equiv_checker_lane (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic upd,
    input  logic res,
    input  logic maj,
    output logic bad
);
    // Sticky flag: this implementation disagreed with the vote at least once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                      bad <= 1'b0;
        else if (clr)                 bad <= 1'b0;
        else if (upd && (res != maj)) bad <= 1'b1;
    end
endmodule

module equiv_checker #(
    parameter int W = 3,
    parameter int N = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         valid_in,
    input  logic [W-1:0] vec_in,
    input  logic [N-1:0] res_in,
    output logic         busy,
    output logic         done,
    output logic         pass,
    output logic         seq_err,
    output logic [W:0]   mism_cnt,
    output logic [W-1:0] first_bad_vec,
    output logic [N-1:0] first_bad_res,
    output logic [N-1:0] bad_mask
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    function automatic int popcnt(input logic [N-1:0] v);
        int c;
        c = 0;
        for (int i = 0; i < N; i++) c += int'(v[i]);
        return c;
    endfunction

    logic [1:0]   state;
    logic [W-1:0] exp_vec;
    logic         take_start, sample, mis, maj, seq_nxt, last;
    logic [W:0]   cnt_nxt;

    // start is only honoured outside RUN; it also masks a coincident valid_in.
    assign take_start = start && (state != RUN);
    assign sample     = (state == RUN) && valid_in;
    assign mis        = !((res_in == '0) || (res_in == '1));
    assign maj        = popcnt(res_in) > (N / 2);
    assign cnt_nxt    = mism_cnt + {{W{1'b0}}, mis};
    assign seq_nxt    = seq_err | (vec_in != exp_vec);
    assign last       = (exp_vec == '1);

    for (genvar i = 0; i < N; i++) begin : g_lane
        equiv_checker_lane u_lane (
            .clk (clk),
            .rst (rst),
            .clr (take_start),
            .upd (sample && mis),
            .res (res_in[i]),
            .maj (maj),
            .bad (bad_mask[i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            exp_vec       <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            seq_err       <= 1'b0;
            mism_cnt      <= '0;
            first_bad_vec <= '0;
            first_bad_res <= '0;
        end else if (take_start) begin
            state         <= RUN;
            exp_vec       <= '0;
            busy          <= 1'b1;
            done          <= 1'b0;
            pass          <= 1'b0;
            seq_err       <= 1'b0;
            mism_cnt      <= '0;
            first_bad_vec <= '0;
            first_bad_res <= '0;
        end else if (sample) begin
            exp_vec  <= exp_vec + 1'b1;
            seq_err  <= seq_nxt;
            mism_cnt <= cnt_nxt;
            if (mis && (mism_cnt == '0)) begin
                first_bad_vec <= vec_in;
                first_bad_res <= res_in;
            end
            // Verdict uses the post-sample values so the final vector is included.
            if (last) begin
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
                pass  <= (cnt_nxt == '0) && !seq_nxt;
            end
        end
    end
endmodule

// File: tb/tb_equiv_checker.sv
// Directed bench for equiv_checker (W=3, N=5) with hand-computed expectations.

module tb_equiv_checker;
    logic       clk = 1'b0;
    logic       rst;
    logic       start, valid_in;
    logic [2:0] vec_in;
    logic [4:0] res_in;
    logic       busy, done, pass, seq_err;
    logic [3:0] mism_cnt;
    logic [2:0] first_bad_vec;
    logic [4:0] first_bad_res, bad_mask;

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0][2:0] v;
    logic [7:0][4:0] r;

    equiv_checker #(.W(3), .N(5)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .valid_in      (valid_in),
        .vec_in        (vec_in),
        .res_in        (res_in),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .seq_err       (seq_err),
        .mism_cnt      (mism_cnt),
        .first_bad_vec (first_bad_vec),
        .first_bad_res (first_bad_res),
        .bad_mask      (bad_mask)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_done_low", done, 0);
        chk("start_cnt_clr", mism_cnt, 0);
    endtask

    task automatic sweep(input logic [7:0][2:0] vv, input logic [7:0][4:0] rr,
                         input bit gaps, input int start_at);
        for (int i = 0; i < 8; i++) begin
            vec_in   = vv[i];
            res_in   = rr[i];
            valid_in = 1'b1;
            start    = (i == start_at);
            tick();
            valid_in = 1'b0;
            start    = 1'b0;
            if (gaps) begin
                vec_in = 3'd0;
                res_in = 5'b10101;
                tick();
                tick();
            end
            if (i == 6) chk("not_done_early", done, 0);
        end
    endtask

    task automatic set_seq();
        for (int i = 0; i < 8; i++) v[i] = 3'(i);
    endtask

    task automatic set_clean();
        for (int i = 0; i < 8; i++) r[i] = (i % 2 == 1) ? 5'b11111 : 5'b00000;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; valid_in = 1'b0; vec_in = '0; res_in = '0;
        #3;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_mism", mism_cnt, 0);
        chk("rst_mask", bad_mask, 0);
        tick();
        rst = 1'b0;
        tick();

        // Clean sweep
        set_seq(); set_clean();
        do_start();
        sweep(v, r, 1'b0, -1);
        chk("clean_done", done, 1);
        chk("clean_busy", busy, 0);
        chk("clean_pass", pass, 1);
        chk("clean_mism", mism_cnt, 0);
        chk("clean_mask", bad_mask, 0);
        chk("clean_seq", seq_err, 0);

        // Single fault: impl 3 flips at vec 5 (restart from DONE)
        for (int i = 0; i < 8; i++) r[i] = 5'b00000;
        r[5] = 5'b01000;
        do_start();
        sweep(v, r, 1'b0, -1);
        chk("single_done", done, 1);
        chk("single_mism", mism_cnt, 1);
        chk("single_fvec", first_bad_vec, 5);
        chk("single_fres", first_bad_res, 5'b01000);
        chk("single_mask", bad_mask, 5'b01000);
        chk("single_pass", pass, 0);

        // Two faults with valid_in gaps
        for (int i = 0; i < 8; i++) r[i] = 5'b11111;
        r[2] = 5'b11110;
        r[6] = 5'b10000;
        do_start();
        sweep(v, r, 1'b1, -1);
        chk("two_done", done, 1);
        chk("two_mism", mism_cnt, 2);
        chk("two_fvec", first_bad_vec, 2);
        chk("two_fres", first_bad_res, 5'b11110);
        chk("two_mask", bad_mask, 5'b10001);
        chk("two_seq", seq_err, 0);
        chk("two_pass", pass, 0);

        // Sequence error: 0,1,3,4,5,6,7,0
        v[0] = 3'd0; v[1] = 3'd1; v[2] = 3'd3; v[3] = 3'd4;
        v[4] = 3'd5; v[5] = 3'd6; v[6] = 3'd7; v[7] = 3'd0;
        for (int i = 0; i < 8; i++) r[i] = 5'b00000;
        do_start();
        sweep(v, r, 1'b0, -1);
        chk("seq_done", done, 1);
        chk("seq_err", seq_err, 1);
        chk("seq_mism", mism_cnt, 0);
        chk("seq_pass", pass, 0);

        // Asynchronous reset mid-run
        set_seq();
        do_start();
        for (int i = 0; i < 4; i++) begin
            vec_in = 3'(i); res_in = (i == 1) ? 5'b00011 : 5'b00000; valid_in = 1'b1;
            tick();
        end
        valid_in = 1'b0;
        chk("mid_mism", mism_cnt, 1);
        chk("mid_mask", bad_mask, 5'b00011);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_mism", mism_cnt, 0);
        chk("arst_mask", bad_mask, 0);
        chk("arst_fvec", first_bad_vec, 0);
        chk("arst_fres", first_bad_res, 0);
        tick();
        rst = 1'b0;
        // IDLE ignores samples without start
        vec_in = 3'd0; res_in = 5'b00011; valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        chk("idle_busy", busy, 0);
        chk("idle_mism", mism_cnt, 0);
        set_clean();
        do_start();
        sweep(v, r, 1'b0, -1);
        chk("post_rst_pass", pass, 1);

        // start during RUN is ignored
        do_start();
        sweep(v, r, 1'b0, 3);
        chk("run_start_done", done, 1);
        chk("run_start_pass", pass, 1);
        chk("run_start_seq", seq_err, 0);

        // start + valid_in in the same DONE cycle: sample dropped
        start = 1'b1; valid_in = 1'b1; vec_in = 3'd0; res_in = 5'b00001;
        tick();
        start = 1'b0; valid_in = 1'b0;
        chk("sv_busy", busy, 1);
        chk("sv_mism", mism_cnt, 0);
        chk("sv_mask", bad_mask, 0);
        sweep(v, r, 1'b0, -1);
        chk("sv_done", done, 1);
        chk("sv_pass", pass, 1);
        chk("sv_seq", seq_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
